// File: rtl/alu_pkg.sv
// Shared constants and the result-entry type for the execute-stage result register.
// DIVZERO_CHECK_EN adds a per-lane divide-by-zero field to the entry.
package alu_pkg;

  localparam int unsigned AluN     = 8;
  localparam int unsigned AluLanes = 4;
  localparam int unsigned AluRw    = 4;

  typedef struct packed {
    logic [AluLanes*AluN-1:0] result;
    logic [AluLanes-1:0]      ovf;
    logic [AluLanes-1:0]      car;
    logic [AluRw-1:0]         rd;
    logic                     we;
`ifdef DIVZERO_CHECK_EN
    logic [AluLanes-1:0]      dz;
`endif
  } alu_res_t;

endpackage

// File: rtl/alu_res_skid.sv
// Generic two-entry valid/ready skid buffer; in_ready_o is registered so upstream never
// sees a combinational path from out_ready_i. Synchronous active-low reset.
module alu_res_skid
  import alu_pkg::*;
#(
  parameter type entry_t = alu_res_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  input  entry_t in_data_i,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output entry_t out_data_o
);

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   accept, drain;

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so no accept can coincide with the skid refill
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_d       = in_data_i;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_data_i;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage output register: buffers ALU lane results toward Memory and keeps a sticky
// overflow flag. DIVZERO_CHECK_EN adds in_is_div/in_bzero/out_dz.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned N     = AluN,
  parameter int unsigned LANES = AluLanes,
  parameter int unsigned RW    = AluRw
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] in_result,
  input  logic [LANES-1:0]   in_ovf,
  input  logic [LANES-1:0]   in_car,
  input  logic [RW-1:0]      in_rd,
  input  logic               in_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_result,
  output logic [LANES-1:0]   out_ovf,
  output logic [LANES-1:0]   out_car,
  output logic [RW-1:0]      out_rd,
  output logic               out_we,
`ifdef DIVZERO_CHECK_EN
  input  logic               in_is_div,
  input  logic [LANES-1:0]   in_bzero,
  output logic [LANES-1:0]   out_dz,
`endif
  input  logic               flush,
  input  logic               clr_flags,
  output logic               sticky_ovf
);

  // Local entry type so non-default lane geometry still packs correctly
  typedef struct packed {
    logic [LANES*N-1:0] result;
    logic [LANES-1:0]   ovf;
    logic [LANES-1:0]   car;
    logic [RW-1:0]      rd;
    logic               we;
`ifdef DIVZERO_CHECK_EN
    logic [LANES-1:0]   dz;
`endif
  } res_t;

  res_t in_ent, out_ent;
  logic accept, flag_hit;
  logic sticky_q, sticky_d;

  always_comb begin
    in_ent        = '0;
    in_ent.result = in_result;
    in_ent.ovf    = in_ovf;
    in_ent.car    = in_car;
    in_ent.rd     = in_rd;
    in_ent.we     = in_we;
`ifdef DIVZERO_CHECK_EN
    in_ent.dz     = in_bzero & {LANES{in_is_div}};
`endif
  end

  alu_res_skid #(
    .entry_t (res_t)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_ent),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_ent)
  );

  assign out_result = out_ent.result;
  assign out_ovf    = out_ent.ovf;
  assign out_car    = out_ent.car;
  assign out_rd     = out_ent.rd;
  assign out_we     = out_ent.we;
`ifdef DIVZERO_CHECK_EN
  assign out_dz     = out_ent.dz;
  assign flag_hit   = (|in_ent.ovf) | (|in_ent.dz);
`else
  assign flag_hit   = |in_ent.ovf;
`endif

  assign accept     = in_valid & in_ready;
  assign sticky_ovf = sticky_q;

  // A new flagged entry beats a same-cycle clear
  always_comb begin
    sticky_d = sticky_q;
    if (accept && flag_hit) begin
      sticky_d = 1'b1;
    end else if (clr_flags) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-stage output register sitting directly downstream of the vector ALU (divisor, adder, multiplier lanes).
- Captures per-lane result, overflow and carry, tags them with the destination vector register, and hands them to the Memory stage over a valid/ready handshake.
- Includes a 2-entry skid buffer so the ALU never sees a combinational ready path from Memory, plus a sticky overflow status register.

Parameters:
- N, 8, lane data width (matches ALU lane width)
- LANES, 4, number of vector lanes
- RW, 4, destination register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_result  in  LANES*N  lane results, lane 0 in bits [N-1:0]
- in_ovf  in  LANES  per-lane overflow
- in_car  in  LANES  per-lane carry
- in_rd  in  RW  destination register
- in_we  in  1  writeback enable
- out_valid  out  1  entry presented to Memory
- out_ready  in  1  Memory accepts
- out_result  out  LANES*N  registered results
- out_ovf  out  LANES  registered overflow
- out_car  out  LANES  registered carry
- out_rd  out  RW  registered destination
- out_we  out  1  registered write enable
- flush  in  1  discard all buffered entries
- clr_flags  in  1  clear sticky status
- sticky_ovf  out  1  any lane overflowed since last clear

Behaviour:
- Reset (rst_n=0 at posedge clk): out_valid=0, in_ready=1, sticky_ovf=0, all out_* data=0, skid entry invalid.
- Storage: main register (drives out_*) plus skid register. in_ready = !skid_valid, registered; never a function of out_ready in the same cycle.
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: accepted data appears on out_* the next cycle when the main register is empty or draining.
- Main empty or draining, skid empty: accepted data goes to main.
- Main full and not draining, accept: data goes to skid; in_ready falls next cycle.
- Drain with skid full: skid moves to main, skid invalid, in_ready rises next cycle; any accept in that cycle is impossible (in_ready was 0).
- Data ordering is strictly FIFO; no entry dropped or duplicated under any out_ready pattern.
- out_* data held stable while out_valid=1 and out_ready=0.
- flush: next cycle out_valid=0 and skid invalid; a simultaneous accept is discarded. Flush wins over everything except reset. sticky_ovf is not affected by flush.
- sticky_ovf: set next cycle when an accepted entry has |in_ovf; cleared by clr_flags. Same-cycle clr_flags and set: set wins.
- Overflowing lanes still pass their truncated result unchanged; this stage never alters data.
- Reset mid-transfer: all entries discarded, sticky cleared.

Optional Feature:
- Macro DIVZERO_CHECK_EN.
- Defined: adds inputs in_is_div (1) and in_bzero (LANES), and output out_dz (LANES), registered and buffered with the entry. The value is in_bzero & {LANES{in_is_div}}. Accepted divide-by-zero lanes also set sticky_ovf.
- Undefined: ports absent, no extra state.

Decomposition:
- Shared package alu_pkg: default N/LANES/RW constants and a packed struct alu_res_t {result, ovf, car, rd, we [, dz]}.
- One sub-module: alu_res_skid, a generic 2-entry valid/ready skid buffer over alu_res_t.
- Top module adds the flush and sticky logic.

Test Plan:
- Reset then in_valid with result 32'h01020304, out_ready=1 -> out_valid=1 next cycle, out_result=32'h01020304, in_ready stays 1.
- out_ready=0, send A=0x11, B=0x22 on back-to-back cycles -> in_ready=0 after B. Raise out_ready -> out_result 0x11 then 0x22, in_ready=1 again.
- in_ovf=4'b0100 accepted -> sticky_ovf=1 next cycle. clr_flags with a new ovf entry in the same cycle -> sticky_ovf stays 1. clr_flags alone -> 0.
- Both entries full, assert flush with in_valid -> out_valid=0 and in_ready=1 next cycle; no stale data appears later.
- Random in_valid/out_ready for 1000 cycles -> scoreboard shows output order equals input order; out_* stable while stalled.
- DIVZERO_CHECK_EN: in_is_div=1, in_bzero=4'b0001 -> out_dz=4'b0001 and sticky_ovf=1.
